// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. buffered mul/div results, plus a
// pending scoreboard for decode hazards. Define WB_LL_BYPASS_EN for same-cycle LL writeback.
module wb_port_arbiter #(
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        PIPE_WB_VALID,
    input  logic [4:0]  PIPE_WB_DES,
    input  logic [31:0] PIPE_WB_DATA,
    input  logic        LL_ISSUE,
    input  logic [4:0]  LL_ISSUE_RD,
    input  logic        LL_RES_VALID,
    input  logic [4:0]  LL_RES_DES,
    input  logic [31:0] LL_RES_DATA,
    output logic        LL_RES_READY,
    input  logic [4:0]  DEC_RS1,
    input  logic [4:0]  DEC_RS2,
    input  logic [4:0]  DEC_RD,
    output logic        DEC_HAZARD,
    output logic        RF_WE,
    output logic [4:0]  RF_DES,
    output logic [31:0] RF_DATA,
    output logic        PIPE_HOLD
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    logic [4:0]      fifo_des_q  [FIFO_DEPTH];
    logic [31:0]     fifo_data_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [31:0]     pend_q, pend_d;
    logic [3:0]      starve_q, starve_d;
    logic [3:0]      starve_inc;
    logic            hold_q, hold_d;
    logic [4:0]      last_des_q, last_des_d;
    logic [31:0]     last_data_q, last_data_d;

    logic        full, empty;
    logic        pipe_grant, pop, push, bypass, rf_we_int;
    logic [4:0]  head_des;
    logic [31:0] head_data;
    logic [4:0]  rf_des_int;
    logic [31:0] rf_data_int;

    assign full      = (count_q == CntW'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign head_des  = fifo_des_q[rd_ptr_q];
    assign head_data = fifo_data_q[rd_ptr_q];

    always_comb begin
        pipe_grant = PIPE_WB_VALID & ~hold_q;
        pop        = ~pipe_grant & ~empty;
        bypass     = 1'b0;
`ifdef WB_LL_BYPASS_EN
        bypass     = ~PIPE_WB_VALID & ~hold_q & empty & LL_RES_VALID;
`endif
        push       = LL_RES_VALID & ~full & ~bypass;
        rf_we_int  = pipe_grant | pop | bypass;

        if (pipe_grant) begin
            rf_des_int  = PIPE_WB_DES;
            rf_data_int = PIPE_WB_DATA;
        end else if (pop) begin
            rf_des_int  = head_des;
            rf_data_int = head_data;
        end else if (bypass) begin
            rf_des_int  = LL_RES_DES;
            rf_data_int = LL_RES_DATA;
        end else begin
            rf_des_int  = last_des_q;
            rf_data_int = last_data_q;
        end

        last_des_d  = rf_we_int ? rf_des_int : last_des_q;
        last_data_d = rf_we_int ? rf_data_int : last_data_q;

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + CntW'(push) - CntW'(pop);

        // Clear first so a same-cycle issue to the retiring register keeps it pending.
        pend_d = pend_q;
        if (pop) begin
            pend_d[head_des] = 1'b0;
        end
        if (bypass) begin
            pend_d[LL_RES_DES] = 1'b0;
        end
        if (LL_ISSUE && (LL_ISSUE_RD != 5'd0)) begin
            pend_d[LL_ISSUE_RD] = 1'b1;
        end
        pend_d[0] = 1'b0;

        starve_inc = starve_q + 4'd1;
        starve_d   = starve_q;
        hold_d     = 1'b0;
        if (pop) begin
            starve_d = 4'd0;
        end else if (pipe_grant && !empty) begin
            if (starve_inc == 4'(STARVE_LIMIT)) begin
                hold_d   = 1'b1;
                starve_d = 4'd0;
            end else begin
                starve_d = starve_inc;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pend_q      <= '0;
            starve_q    <= '0;
            hold_q      <= 1'b0;
            last_des_q  <= '0;
            last_data_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pend_q      <= pend_d;
            starve_q    <= starve_d;
            hold_q      <= hold_d;
            last_des_q  <= last_des_d;
            last_data_q <= last_data_d;
        end
    end

    // Storage needs no reset; occupancy alone decides validity.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_des_q[wr_ptr_q]  <= LL_RES_DES;
            fifo_data_q[wr_ptr_q] <= LL_RES_DATA;
        end
    end

    assign LL_RES_READY = ~full;
    assign DEC_HAZARD   = pend_q[DEC_RS1] | pend_q[DEC_RS2] | pend_q[DEC_RD];
    assign RF_WE        = rf_we_int & RST_N;
    assign RF_DES       = rf_des_int;
    assign RF_DATA      = rf_data_int;
    assign PIPE_HOLD    = hold_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios followed by random traffic,
// all compared against a queue-based reference model.
module tb_wb_port_arbiter;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned LIMIT = 4;

    logic        CLK, RST_N;
    logic        PIPE_WB_VALID;
    logic [4:0]  PIPE_WB_DES;
    logic [31:0] PIPE_WB_DATA;
    logic        LL_ISSUE;
    logic [4:0]  LL_ISSUE_RD;
    logic        LL_RES_VALID;
    logic [4:0]  LL_RES_DES;
    logic [31:0] LL_RES_DATA;
    logic        LL_RES_READY;
    logic [4:0]  DEC_RS1, DEC_RS2, DEC_RD;
    logic        DEC_HAZARD;
    logic        RF_WE;
    logic [4:0]  RF_DES;
    logic [31:0] RF_DATA;
    logic        PIPE_HOLD;

    wb_port_arbiter #(
        .FIFO_DEPTH  (DEPTH),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .PIPE_WB_VALID(PIPE_WB_VALID),
        .PIPE_WB_DES  (PIPE_WB_DES),
        .PIPE_WB_DATA (PIPE_WB_DATA),
        .LL_ISSUE     (LL_ISSUE),
        .LL_ISSUE_RD  (LL_ISSUE_RD),
        .LL_RES_VALID (LL_RES_VALID),
        .LL_RES_DES   (LL_RES_DES),
        .LL_RES_DATA  (LL_RES_DATA),
        .LL_RES_READY (LL_RES_READY),
        .DEC_RS1      (DEC_RS1),
        .DEC_RS2      (DEC_RS2),
        .DEC_RD       (DEC_RD),
        .DEC_HAZARD   (DEC_HAZARD),
        .RF_WE        (RF_WE),
        .RF_DES       (RF_DES),
        .RF_DATA      (RF_DATA),
        .PIPE_HOLD    (PIPE_HOLD)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [4:0]  des;
        logic [31:0] data;
    } res_t;

    int vectors = 0;
    int miscompares = 0;

    res_t        ll_q[$];
    bit          pend[32];
    int          starve;
    bit          m_hold;
    logic [4:0]  last_des;
    logic [31:0] last_data;
    bit          prev_hold;

    bit          e_ready, e_haz, e_pipe, e_pop, e_push, e_bypass, e_we, e_nonempty;
    logic [4:0]  e_des;
    logic [31:0] e_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ll_q.delete();
        foreach (pend[i]) pend[i] = 1'b0;
        starve    = 0;
        m_hold    = 1'b0;
        last_des  = '0;
        last_data = '0;
        prev_hold = 1'b0;
    endtask

    task automatic idle_inputs();
        PIPE_WB_VALID = 1'b0; PIPE_WB_DES = '0; PIPE_WB_DATA = '0;
        LL_ISSUE = 1'b0; LL_ISSUE_RD = '0;
        LL_RES_VALID = 1'b0; LL_RES_DES = '0; LL_RES_DATA = '0;
        DEC_RS1 = '0; DEC_RS2 = '0; DEC_RD = '0;
    endtask

    function automatic bit is_pend(input logic [4:0] r);
        return (r != 5'd0) && pend[r];
    endfunction

    // Compute the expected outputs for the current inputs and compare them mid-cycle.
    task automatic eval();
        @(negedge CLK);
        e_nonempty = (ll_q.size() != 0);
        e_ready    = (ll_q.size() < DEPTH);
        e_haz      = is_pend(DEC_RS1) || is_pend(DEC_RS2) || is_pend(DEC_RD);
        e_pipe     = PIPE_WB_VALID && !m_hold;
        e_pop      = !e_pipe && e_nonempty;
        e_bypass   = 1'b0;
`ifdef WB_LL_BYPASS_EN
        e_bypass   = !PIPE_WB_VALID && !m_hold && !e_nonempty && LL_RES_VALID;
`endif
        e_push     = LL_RES_VALID && e_ready && !e_bypass;
        e_we       = e_pipe || e_pop || e_bypass;
        if (e_pipe) begin
            e_des = PIPE_WB_DES;  e_data = PIPE_WB_DATA;
        end else if (e_pop) begin
            e_des = ll_q[0].des;  e_data = ll_q[0].data;
        end else if (e_bypass) begin
            e_des = LL_RES_DES;   e_data = LL_RES_DATA;
        end else begin
            e_des = last_des;     e_data = last_data;
        end
        chk("ll_res_ready", LL_RES_READY, e_ready);
        chk("dec_hazard", DEC_HAZARD, e_haz);
        chk("rf_we", RF_WE, e_we);
        chk("rf_des", RF_DES, e_des);
        chk("rf_data", RF_DATA, e_data);
        chk("pipe_hold", PIPE_HOLD, m_hold);
        chk("hold_back_to_back", prev_hold & PIPE_HOLD, 1'b0);
        prev_hold = PIPE_HOLD;
    endtask

    task automatic advance();
        res_t r;
        bit   nh;
        @(posedge CLK);
        if (e_we) begin
            last_des  = e_des;
            last_data = e_data;
        end
        if (e_pop) begin
            pend[ll_q[0].des] = 1'b0;
            r = ll_q.pop_front();
        end
        if (e_bypass) pend[LL_RES_DES] = 1'b0;
        if (e_push) begin
            r.des  = LL_RES_DES;
            r.data = LL_RES_DATA;
            ll_q.push_back(r);
        end
        if (LL_ISSUE && LL_ISSUE_RD != 5'd0) pend[LL_ISSUE_RD] = 1'b1;
        nh = 1'b0;
        if (e_pop) begin
            starve = 0;
        end else if (e_pipe && e_nonempty) begin
            starve++;
            if (starve == LIMIT) begin
                nh     = 1'b1;
                starve = 0;
            end
        end
        m_hold = nh;
        #1;
    endtask

    task automatic step();
        eval();
        advance();
    endtask

    initial begin
        RST_N = 1'b0;
        idle_inputs();
        model_reset();
        PIPE_WB_VALID = 1'b1;
        #1;
        chk("rst_rf_we_forced", RF_WE, 1'b0);
        idle_inputs();
        repeat (2) @(posedge CLK);
        @(negedge CLK) RST_N = 1'b1;
        @(posedge CLK);
        #1;

        // Idle after reset
        eval();
        chk("rst_ready", LL_RES_READY, 1'b1);
        chk("rst_hazard", DEC_HAZARD, 1'b0);
        chk("rst_we", RF_WE, 1'b0);
        chk("rst_hold", PIPE_HOLD, 1'b0);
        chk("rst_des", RF_DES, 5'd0);
        chk("rst_data", RF_DATA, 32'd0);
        advance();

        // Issue rd=5, hazard, result through FIFO, hazard clears
        LL_ISSUE = 1'b1; LL_ISSUE_RD = 5'd5;
        step();
        LL_ISSUE = 1'b0; DEC_RS1 = 5'd5;
        eval();
        chk("haz_rd5", DEC_HAZARD, 1'b1);
        advance();
        LL_RES_VALID = 1'b1; LL_RES_DES = 5'd5; LL_RES_DATA = 32'hDEAD_BEEF;
        step();
        LL_RES_VALID = 1'b0;
        eval();
        chk("ll_wr_we", RF_WE, 1'b1);
        chk("ll_wr_des", RF_DES, 5'd5);
        chk("ll_wr_data", RF_DATA, 32'hDEAD_BEEF);
        advance();
        eval();
        chk("haz_rd5_clear", DEC_HAZARD, 1'b0);
        advance();

        // Pipeline beats pending FIFO head, head writes on first idle slot
        idle_inputs();
        LL_ISSUE = 1'b1; LL_ISSUE_RD = 5'd7;
        step();
        LL_ISSUE = 1'b0;
        LL_RES_VALID = 1'b1; LL_RES_DES = 5'd7; LL_RES_DATA = 32'h7777_0007;
        PIPE_WB_VALID = 1'b1; PIPE_WB_DES = 5'd3; PIPE_WB_DATA = 32'h3333_0003;
        step();
        LL_RES_VALID = 1'b0; PIPE_WB_DATA = 32'h3333_0004;
        eval();
        chk("prio_pipe_des", RF_DES, 5'd3);
        advance();
        PIPE_WB_VALID = 1'b0;
        eval();
        chk("prio_ll_des", RF_DES, 5'd7);
        chk("prio_ll_data", RF_DATA, 32'h7777_0007);
        advance();

        // Starvation: hold after LIMIT denied cycles
        PIPE_WB_VALID = 1'b1; PIPE_WB_DES = 5'd4; PIPE_WB_DATA = 32'h4444_0000;
        LL_RES_VALID = 1'b1; LL_RES_DES = 5'd12; LL_RES_DATA = 32'hC0C0_C0C0;
        step();
        LL_RES_VALID = 1'b0;
        for (int i = 0; i < LIMIT; i++) begin
            eval();
            chk("starve_no_hold", PIPE_HOLD, 1'b0);
            chk("starve_pipe_des", RF_DES, 5'd4);
            advance();
        end
        eval();
        chk("starve_hold", PIPE_HOLD, 1'b1);
        chk("starve_we", RF_WE, 1'b1);
        chk("starve_head_des", RF_DES, 5'd12);
        chk("starve_head_data", RF_DATA, 32'hC0C0_C0C0);
        advance();
        eval();
        chk("starve_hold_drop", PIPE_HOLD, 1'b0);
        chk("starve_pipe_back", RF_DES, 5'd4);
        advance();

        // FIFO full back-pressure
        PIPE_WB_DES = 5'd2;
        LL_RES_VALID = 1'b1; LL_RES_DES = 5'd20; LL_RES_DATA = 32'hA000_0020;
        step();
        LL_RES_DES = 5'd21; LL_RES_DATA = 32'hA000_0021;
        step();
        LL_RES_DES = 5'd22; LL_RES_DATA = 32'hA000_0022;
        eval();
        chk("full_ready", LL_RES_READY, 1'b0);
        advance();
        PIPE_WB_VALID = 1'b0;
        eval();
        chk("full_pop_ready", LL_RES_READY, 1'b0);
        chk("full_pop_des", RF_DES, 5'd20);
        advance();
        eval();
        chk("refill_ready", LL_RES_READY, 1'b1);
        chk("refill_des", RF_DES, 5'd21);
        advance();
        LL_RES_VALID = 1'b0;
        eval();
        chk("third_des", RF_DES, 5'd22);
        chk("third_data", RF_DATA, 32'hA000_0022);
        advance();

        // Set wins over clear, then async reset mid-operation
        idle_inputs();
        LL_ISSUE = 1'b1; LL_ISSUE_RD = 5'd9;
        step();
        LL_ISSUE = 1'b0;
        LL_RES_VALID = 1'b1; LL_RES_DES = 5'd9; LL_RES_DATA = 32'h0000_0099;
        step();
        LL_RES_VALID = 1'b0;
        LL_ISSUE = 1'b1; LL_ISSUE_RD = 5'd9;
        eval();
        chk("retire9_des", RF_DES, 5'd9);
        advance();
        LL_ISSUE = 1'b0; DEC_RD = 5'd9;
        eval();
        chk("set_wins_haz", DEC_HAZARD, 1'b1);
        advance();
        PIPE_WB_VALID = 1'b1; PIPE_WB_DES = 5'd1;
        LL_RES_VALID = 1'b1; LL_RES_DES = 5'd14;
        step();
        LL_RES_DES = 5'd15;
        step();
        #2 RST_N = 1'b0;
        #1;
        chk("arst_ready", LL_RES_READY, 1'b1);
        chk("arst_hazard", DEC_HAZARD, 1'b0);
        chk("arst_we", RF_WE, 1'b0);
        chk("arst_hold", PIPE_HOLD, 1'b0);
        model_reset();
        idle_inputs();
        @(posedge CLK);
        @(negedge CLK) RST_N = 1'b1;
        @(posedge CLK);
        #1;

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            PIPE_WB_VALID = ($urandom_range(0, 99) < 55);
            PIPE_WB_DES   = 5'($urandom_range(0, 31));
            PIPE_WB_DATA  = $urandom;
            LL_ISSUE      = ($urandom_range(0, 99) < 20);
            LL_ISSUE_RD   = 5'($urandom_range(0, 31));
            LL_RES_VALID  = ($urandom_range(0, 99) < 30);
            LL_RES_DES    = 5'($urandom_range(0, 31));
            LL_RES_DATA   = $urandom;
            DEC_RS1       = 5'($urandom_range(0, 31));
            DEC_RS2       = 5'($urandom_range(0, 31));
            DEC_RD        = 5'($urandom_range(0, 31));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
